// File: rtl/pooler_stream_if.sv
// rtl/pooler_stream_if.sv - sample-in / pooled-out stream bundle for pooler_stream
interface pooler_stream_if #(
    parameter int DATA_WIDTH = 16
);
    logic [1:0]                   mode;
    logic signed [DATA_WIDTH-1:0] in_data;
    logic                         in_valid;
    logic                         in_ready;
    logic signed [DATA_WIDTH-1:0] out_data;
    logic                         out_valid;
    logic                         out_ready;
    logic                         frame_done;

    modport slave (
        input  mode, in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, frame_done
    );

    modport master (
        output mode, in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, frame_done
    );
endinterface

// File: rtl/pooler_stream.sv
// rtl/pooler_stream.sv - streaming non-overlapping 2D avg/max/min pooling engine
module pooler_stream #(
    parameter int INPUT_SIZE = 8,
    parameter int POOL_SIZE  = 2,
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = DATA_WIDTH + 2 * $clog2(POOL_SIZE)
) (
    input  logic             clk,
    input  logic             master_rst,
    pooler_stream_if.slave   bus
);
    localparam int LOG2P     = $clog2(POOL_SIZE);
    localparam int NWIN      = INPUT_SIZE / POOL_SIZE;
    localparam int VALID_LIM = NWIN * POOL_SIZE;
    localparam int CW        = $clog2(INPUT_SIZE);
    localparam int WIDX      = (NWIN > 1) ? $clog2(NWIN) : 1;
    localparam int SH        = 2 * LOG2P;
    localparam int EXT       = ACC_WIDTH - DATA_WIDTH;
    localparam logic signed [ACC_WIDTH-1:0] ROUND = ACC_WIDTH'(2 ** (SH - 1));

    logic [CW-1:0]                r_row;
    logic [CW-1:0]                r_col;
    logic [1:0]                   r_mode;
    logic signed [ACC_WIDTH-1:0]  r_buf [0:NWIN-1];
    logic signed [DATA_WIDTH-1:0] r_out_data;
    logic                         r_out_valid;
    logic                         r_out_last;

    logic                         w_accept;
    logic                         w_first_pix;
    logic [1:0]                   w_mode_eff;
    logic                         w_in_win;
    logic                         w_win_first;
    logic                         w_win_last;
    logic                         w_frame_last;
    logic [WIDX-1:0]              w_wc;
    logic signed [ACC_WIDTH-1:0]  w_ext;
    logic signed [ACC_WIDTH-1:0]  w_entry;
    logic signed [ACC_WIDTH-1:0]  w_comb;
    logic signed [ACC_WIDTH-1:0]  w_rnd;
    logic signed [ACC_WIDTH-1:0]  w_avg;
    logic signed [DATA_WIDTH-1:0] w_result;

    assign bus.in_ready   = ~r_out_valid | bus.out_ready;
    assign bus.out_data   = r_out_data;
    assign bus.out_valid  = r_out_valid;
    assign bus.frame_done = r_out_valid & bus.out_ready & r_out_last;

    assign w_accept     = bus.in_valid & bus.in_ready;
    assign w_first_pix  = (r_row == '0) && (r_col == '0);
    // The first beat of a frame already uses the mode it is about to latch.
    assign w_mode_eff   = w_first_pix ? bus.mode : r_mode;
    assign w_in_win     = (int'(r_row) < VALID_LIM) && (int'(r_col) < VALID_LIM);
    assign w_win_first  = (r_row[LOG2P-1:0] == '0) && (r_col[LOG2P-1:0] == '0);
    assign w_win_last   = (r_row[LOG2P-1:0] == '1) && (r_col[LOG2P-1:0] == '1);
    assign w_frame_last = (int'(r_row) == VALID_LIM - 1) && (int'(r_col) == VALID_LIM - 1);
    assign w_wc         = WIDX'(r_col >> LOG2P);
    assign w_ext        = {{EXT{bus.in_data[DATA_WIDTH-1]}}, bus.in_data};
    assign w_entry      = r_buf[w_wc];

    always_comb begin
        w_comb = w_ext;
        if (!w_win_first) begin
            case (w_mode_eff)
                2'b00:   w_comb = w_entry + w_ext;
                2'b10:   w_comb = (w_ext < w_entry) ? w_ext : w_entry;
                default: w_comb = (w_ext > w_entry) ? w_ext : w_entry;
            endcase
        end
    end

    // Adding half an LSB before the arithmetic shift rounds half toward +inf.
    assign w_rnd    = w_comb + ROUND;
    assign w_avg    = w_rnd >>> SH;
    assign w_result = (w_mode_eff == 2'b00) ? w_avg[DATA_WIDTH-1:0] : w_comb[DATA_WIDTH-1:0];

    always_ff @(posedge clk or negedge master_rst) begin
        if (!master_rst) begin
            r_row       <= '0;
            r_col       <= '0;
            r_mode      <= 2'b00;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            for (int i = 0; i < NWIN; i++) begin
                r_buf[i] <= '0;
            end
        end else begin
            if (w_accept) begin
                if (r_col == CW'(INPUT_SIZE - 1)) begin
                    r_col <= '0;
                    if (r_row == CW'(INPUT_SIZE - 1)) begin
                        r_row <= '0;
                    end else begin
                        r_row <= r_row + CW'(1);
                    end
                end else begin
                    r_col <= r_col + CW'(1);
                end
                if (w_first_pix) begin
                    r_mode <= bus.mode;
                end
                if (w_in_win) begin
                    r_buf[w_wc] <= w_comb;
                end
            end
            if (w_accept && w_in_win && w_win_last) begin
                r_out_data  <= w_result;
                r_out_valid <= 1'b1;
                r_out_last  <= w_frame_last;
            end else if (bus.out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_pooler_stream.sv
// tb/tb_pooler_stream.sv - scoreboard bench for pooler_stream on 4x4 and 5x5 maps
module tb_pooler_stream;
    logic clk = 1'b0;
    logic master_rst;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int data;
        bit last;
        int cyc;
        bit lat;
    } exp_t;

    exp_t q4[$];
    exp_t q5[$];

    pooler_stream_if #(.DATA_WIDTH(16)) if4();
    pooler_stream_if #(.DATA_WIDTH(16)) if5();

    pooler_stream #(.INPUT_SIZE(4), .POOL_SIZE(2), .DATA_WIDTH(16)) u_dut4 (
        .clk        (clk),
        .master_rst (master_rst),
        .bus        (if4)
    );

    pooler_stream #(.INPUT_SIZE(5), .POOL_SIZE(2), .DATA_WIDTH(16)) u_dut5 (
        .clk        (clk),
        .master_rst (master_rst),
        .bus        (if5)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic mon(input int which);
        logic v, r, fd;
        int   d;
        exp_t e;
        bit   empty;
        if (which == 4) begin
            v = if4.out_valid; r = if4.out_ready; fd = if4.frame_done; d = int'(if4.out_data);
            empty = (q4.size() == 0);
        end else begin
            v = if5.out_valid; r = if5.out_ready; fd = if5.frame_done; d = int'(if5.out_data);
            empty = (q5.size() == 0);
        end
        if (v && r) begin
            if (empty) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output dut=%0d actual=%0d required=none", which, d);
            end else begin
                if (which == 4) e = q4.pop_front();
                else            e = q5.pop_front();
                chk($sformatf("out_data_dut%0d", which), d, e.data);
                chk($sformatf("frame_done_dut%0d", which), int'(fd), int'(e.last));
                if (e.lat) chk($sformatf("latency_dut%0d", which), cyc, e.cyc + 1);
            end
        end else if (fd) begin
            checks++;
            errors++;
            $display("FAIL spurious_frame_done dut=%0d actual=1 required=0", which);
        end
    endtask

    always begin
        @(negedge clk);
        #2;
        mon(4);
        mon(5);
    end

    task automatic drive(input int which, input bit v, input int d, input logic [1:0] m);
        if (which == 4) begin
            if4.in_valid = v; if4.in_data = 16'(d); if4.mode = m;
        end else begin
            if5.in_valid = v; if5.in_data = 16'(d); if5.mode = m;
        end
    endtask

    // Presents one sample until it is seen ready; it is taken on the following rising edge.
    task automatic beat(input int which, input int v, input logic [1:0] m, output int stamp);
        logic r;
        int   n;
        n = 0;
        do begin
            @(negedge clk);
            drive(which, 1'b1, v, m);
            #1;
            r = (which == 4) ? if4.in_ready : if5.in_ready;
            stamp = cyc;
            n++;
        end while (!r && n < 200);
        if (!r) begin
            checks++;
            errors++;
            $display("FAIL beat_timeout dut=%0d actual=not_ready required=ready", which);
        end
    endtask

    task automatic push(input int which, input int d, input bit last, input int st, input bit lat);
        exp_t e;
        e.data = d; e.last = last; e.cyc = st; e.lat = lat;
        if (which == 4) q4.push_back(e);
        else            q5.push_back(e);
    endtask

    task automatic send_frame(input int which, input int n, input int first, input int step,
                              input logic [1:0] m, input int comp[4], input int expv[4]);
        int st;
        for (int i = 0; i < n; i++) begin
            beat(which, first + i * step, m, st);
            for (int k = 0; k < 4; k++) begin
                if (i == comp[k]) push(which, expv[k], (k == 3), st, 1'b1);
            end
        end
        @(negedge clk);
        drive(which, 1'b0, 0, m);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q4.size() != 0 || q5.size() != 0) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (q4.size() != 0 || q5.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout actual=%0d_pending required=0", q4.size() + q5.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int st;
        int c4[4];
        int c5[4];
        c4 = '{5, 7, 13, 15};
        c5 = '{6, 8, 16, 18};
        master_rst = 1'b0;
        drive(4, 1'b0, 0, 2'b00);
        drive(5, 1'b0, 0, 2'b00);
        if4.out_ready = 1'b1;
        if5.out_ready = 1'b1;

        @(negedge clk);
        #1;
        chk("rst_out_valid", int'(if4.out_valid), 0);
        chk("rst_out_data", int'(if4.out_data), 0);
        chk("rst_frame_done", int'(if4.frame_done), 0);
        repeat (2) @(negedge clk);
        master_rst = 1'b1;
        #1;
        chk("rst_in_ready4", int'(if4.in_ready), 1);
        chk("rst_in_ready5", int'(if5.in_ready), 1);

        send_frame(4, 16, 1, 1, 2'b01, c4, '{6, 8, 14, 16});
        drain();
        send_frame(4, 16, 1, 1, 2'b00, c4, '{4, 6, 12, 14});
        drain();
        send_frame(4, 16, -1, -1, 2'b10, c4, '{-6, -8, -14, -16});
        drain();
        send_frame(4, 16, -1, -1, 2'b00, c4, '{-3, -5, -11, -13});
        drain();
        send_frame(4, 16, -1, -1, 2'b11, c4, '{-1, -3, -9, -11});
        drain();

        for (int i = 0; i < 6; i++) begin
            beat(4, i + 1, 2'b01, st);
            if (i == 5) push(4, 6, 1'b0, st, 1'b0);
        end
        @(negedge clk);
        if4.out_ready = 1'b0;
        drive(4, 1'b1, 7, 2'b01);
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("bp_out_data", int'(if4.out_data), 6);
            chk("bp_out_valid", int'(if4.out_valid), 1);
            chk("bp_in_ready", int'(if4.in_ready), 0);
            @(negedge clk);
        end
        drive(4, 1'b0, 0, 2'b01);
        if4.out_ready = 1'b1;
        for (int i = 6; i < 16; i++) begin
            beat(4, i + 1, 2'b01, st);
            if (i == 7)  push(4, 8, 1'b0, st, 1'b1);
            if (i == 13) push(4, 14, 1'b0, st, 1'b1);
            if (i == 15) push(4, 16, 1'b1, st, 1'b1);
        end
        @(negedge clk);
        drive(4, 1'b0, 0, 2'b01);
        drain();

        send_frame(5, 25, 1, 1, 2'b01, c5, '{7, 9, 17, 19});
        send_frame(5, 25, 1, 1, 2'b00, c5, '{4, 6, 14, 16});
        drain();

        for (int i = 0; i < 7; i++) begin
            beat(4, 101 + i, 2'b10, st);
            if (i == 5) push(4, 101, 1'b0, st, 1'b1);
        end
        @(negedge clk);
        drive(4, 1'b0, 0, 2'b01);
        master_rst = 1'b0;
        #1;
        chk("midrst_out_valid", int'(if4.out_valid), 0);
        chk("midrst_out_data", int'(if4.out_data), 0);
        repeat (2) @(negedge clk);
        master_rst = 1'b1;
        #1;
        chk("midrst_in_ready", int'(if4.in_ready), 1);
        send_frame(4, 16, 1, 1, 2'b01, c4, '{6, 8, 14, 16});
        drain();

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
